// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file with busy scoreboard: default
// geometry, the hard-wired zero register address, and word/address types
// sized for the default geometry.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int N_BITS_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [N_BITS_DEF-1:0] reg_word_t;
  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_sb_if.sv
// ---------------------------------------------------------------------------
// register_file_sb_if
// Bundles the write-back, read-operand and scoreboard signals of the
// register file.
//   master : decode / write-back side (drives addresses, data, busy set)
//   slave  : the register file (drives read data, busy flags, conflict)
// ---------------------------------------------------------------------------
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int N_bits = N_BITS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              Reg_Write_i;
  logic [ADDR_W-1:0] Write_Register_i;
  logic [N_bits-1:0] Write_Data_i;
  logic [ADDR_W-1:0] Read_Register_1_i;
  logic [ADDR_W-1:0] Read_Register_2_i;
  logic [N_bits-1:0] Read_Data_1_o;
  logic [N_bits-1:0] Read_Data_2_o;
  logic              Busy_Set_i;
  logic [ADDR_W-1:0] Busy_Register_i;
  logic              Read_Busy_1_o;
  logic              Read_Busy_2_o;
  logic              Busy_Conflict_o;

  modport master (
    output Reg_Write_i, Write_Register_i, Write_Data_i,
    output Read_Register_1_i, Read_Register_2_i,
    output Busy_Set_i, Busy_Register_i,
    input  Read_Data_1_o, Read_Data_2_o,
    input  Read_Busy_1_o, Read_Busy_2_o, Busy_Conflict_o
  );

  modport slave (
    input  Reg_Write_i, Write_Register_i, Write_Data_i,
    input  Read_Register_1_i, Read_Register_2_i,
    input  Busy_Set_i, Busy_Register_i,
    output Read_Data_1_o, Read_Data_2_o,
    output Read_Busy_1_o, Read_Busy_2_o, Busy_Conflict_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per register plus a sticky conflict flag.
//   clk, reset          : clock, asynchronous active-high reset
//   i_set, i_set_addr   : mark a register as pending a write
//   i_clr, i_clr_addr   : write-back retiring a register
//   i_rd_addr_1/2       : read-port addresses
//   o_busy_1/2          : raw busy bits of the read-port addresses
//   o_conflict          : set when a busy register is marked again, sticky
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr_1,
  input  logic [ADDR_W-1:0] i_rd_addr_2,
  output logic              o_busy_1,
  output logic              o_busy_2,
  output logic              o_conflict
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] r_busy;
  logic             r_conflict;
  logic             w_set_ok;
  logic             w_clr_same;

  // The zero register is never a write target, so it can never go busy.
  assign w_set_ok   = i_set && !((ZERO_REG != 0) && (i_set_addr == ZERO_ADDR));
  assign w_clr_same = i_clr && (i_clr_addr == i_set_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (i_clr) r_busy[i_clr_addr] <= 1'b0;
      // NOTE: with non-blocking assignments the last one to the same bit wins,
      // so placing the set after the clear gives the new producer priority.
      if (w_set_ok) r_busy[i_set_addr] <= 1'b1;
      if (w_set_ok && r_busy[i_set_addr] && !w_clr_same) r_conflict <= 1'b1;
    end
  end

  assign o_busy_1   = r_busy[i_rd_addr_1];
  assign o_busy_2   = r_busy[i_rd_addr_2];
  assign o_conflict = r_conflict;

endmodule

// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
// 2-read / 1-write register file for the decode stage, with optional
// hard-wired zero register, optional same-cycle write-to-read bypass and a
// per-register busy scoreboard for long-latency producers.
//   clk   : rising-edge clock
//   reset : asynchronous reset, active high
//   bus   : register_file_sb_if.slave (write port, two read ports, busy set,
//           busy flags per read port, sticky conflict flag)
// ---------------------------------------------------------------------------
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int N_bits   = N_BITS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_sb_if.slave  bus
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [N_bits-1:0] r_mem [DEPTH];

  logic              w_we;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_ra    [2];
  logic [1:0]        w_raw_busy;
  logic [N_bits-1:0] w_rdata [2];
  logic [1:0]        w_rbusy;

  // A write seen while reset is held must neither land nor be forwarded.
  assign w_we    = bus.Reg_Write_i & ~reset;
  assign w_wr_ok = w_we && !((ZERO_REG != 0) && (bus.Write_Register_i == ZERO_ADDR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset because reads of never-written registers
      // must return 0; this keeps it out of plain RAM macros.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.Write_Register_i] <= bus.Write_Data_i;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_set       (bus.Busy_Set_i),
    .i_set_addr  (bus.Busy_Register_i),
    .i_clr       (w_we),
    .i_clr_addr  (bus.Write_Register_i),
    .i_rd_addr_1 (bus.Read_Register_1_i),
    .i_rd_addr_2 (bus.Read_Register_2_i),
    .o_busy_1    (w_raw_busy[0]),
    .o_busy_2    (w_raw_busy[1]),
    .o_conflict  (bus.Busy_Conflict_o)
  );

  assign w_ra[0] = bus.Read_Register_1_i;
  assign w_ra[1] = bus.Read_Register_2_i;

  // Zero register masking takes priority over the bypass; a forwarded
  // operand is never reported busy because its data is already here.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: defaults first so every path assigns both outputs (no latch).
      w_rdata[p] = r_mem[w_ra[p]];
      w_rbusy[p] = w_raw_busy[p];
      if ((ZERO_REG != 0) && (w_ra[p] == ZERO_ADDR)) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end else if ((BYPASS != 0) && w_we && (bus.Write_Register_i == w_ra[p])) begin
        w_rdata[p] = bus.Write_Data_i;
        w_rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.Read_Data_1_o = w_rdata[0];
  assign bus.Read_Data_2_o = w_rdata[1];
  assign bus.Read_Busy_1_o = w_rbusy[0];
  assign bus.Read_Busy_2_o = w_rbusy[1];

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // dut_a: defaults (bypass on), dut_b: bypass off, dut_c: 64-bit x 64 regs
  register_file_sb_if #(.N_bits(32), .ADDR_W(5)) ifa ();
  register_file_sb_if #(.N_bits(32), .ADDR_W(5)) ifb ();
  register_file_sb_if #(.N_bits(64), .ADDR_W(6)) ifc ();

  register_file_sb #(.N_bits(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .reset(rst), .bus(ifa));
  register_file_sb #(.N_bits(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
    dut_b (.clk(clk), .reset(rst), .bus(ifb));
  register_file_sb #(.N_bits(64), .ADDR_W(6), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .reset(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      we;
    reg_addr_t waddr;
    reg_word_t wdata;
    logic      set;
    reg_addr_t baddr;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_word_t e_d1;
    reg_word_t e_d2;
    logic      e_b1;
    logic      e_b2;
    logic      e_cf;
  } vec_t;

  vec_t vecs [32];
  int   n_vecs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input int waddr, input reg_word_t wdata,
                     input logic set, input int baddr, input int ra1, input int ra2,
                     input reg_word_t e_d1, input reg_word_t e_d2,
                     input logic e_b1, input logic e_b2, input logic e_cf);
    vecs[n_vecs] = '{we, reg_addr_t'(waddr), wdata, set, reg_addr_t'(baddr),
                     reg_addr_t'(ra1), reg_addr_t'(ra2), e_d1, e_d2, e_b1, e_b2, e_cf};
    n_vecs++;
  endtask

  task automatic idle_all();
    ifa.Reg_Write_i = 0; ifa.Write_Register_i = '0; ifa.Write_Data_i = '0;
    ifa.Busy_Set_i = 0;  ifa.Busy_Register_i = '0;
    ifb.Reg_Write_i = 0; ifb.Write_Register_i = '0; ifb.Write_Data_i = '0;
    ifb.Busy_Set_i = 0;  ifb.Busy_Register_i = '0;
    ifc.Reg_Write_i = 0; ifc.Write_Register_i = '0; ifc.Write_Data_i = '0;
    ifc.Busy_Set_i = 0;  ifc.Busy_Register_i = '0;
  endtask

  initial begin
    // Each row: inputs driven after a falling edge, outputs compared before
    // the following rising edge (which then commits the row).
    add(0,  0, 32'h0,        0,  0,  5, 31, 32'h0,        32'h0,        0, 0, 0);
    add(1,  8, 32'hDEADBEEF, 0,  0,  8,  8, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    add(0,  0, 32'h0,        0,  0,  8,  8, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    add(1,  0, 32'h12345678, 0,  0,  0,  0, 32'h0,        32'h0,        0, 0, 0);
    add(0,  0, 32'h0,        1,  0,  0,  0, 32'h0,        32'h0,        0, 0, 0);
    add(0,  0, 32'h0,        0,  0,  0,  0, 32'h0,        32'h0,        0, 0, 0);
    add(0,  0, 32'h0,        1, 10, 10, 10, 32'h0,        32'h0,        0, 0, 0);
    add(0,  0, 32'h0,        0,  0, 10, 10, 32'h0,        32'h0,        1, 1, 0);
    add(1, 10, 32'hA5,       0,  0, 10, 10, 32'hA5,       32'hA5,       0, 0, 0);
    add(0,  0, 32'h0,        0,  0, 10,  8, 32'hA5,       32'hDEADBEEF, 0, 0, 0);
    add(1, 10, 32'h77,       1, 10, 10, 10, 32'h77,       32'h77,       0, 0, 0);
    add(0,  0, 32'h0,        0,  0, 10, 10, 32'h77,       32'h77,       1, 1, 0);
    add(1, 10, 32'h99,       1, 10, 10, 10, 32'h99,       32'h99,       0, 0, 0);
    add(0,  0, 32'h0,        0,  0, 10, 10, 32'h99,       32'h99,       1, 1, 0);
    add(0,  0, 32'h0,        1,  3,  3, 10, 32'h0,        32'h99,       0, 1, 0);
    add(0,  0, 32'h0,        1,  3,  3,  3, 32'h0,        32'h0,        1, 1, 0);
    add(0,  0, 32'h0,        0,  0,  3, 10, 32'h0,        32'h99,       1, 1, 1);
    add(1,  3, 32'h3,        0,  0,  3,  3, 32'h3,        32'h3,        0, 0, 1);
    add(0,  0, 32'h0,        0,  0,  3, 31, 32'h3,        32'h0,        0, 0, 1);
    add(0,  0, 32'h0,        0,  0,  8, 31, 32'hDEADBEEF, 32'h0,        0, 0, 1);

    // Reset phase
    rst = 1'b1;
    idle_all();
    ifa.Read_Register_1_i = 5'd5;  ifa.Read_Register_2_i = 5'd31;
    ifb.Read_Register_1_i = 5'd0;  ifb.Read_Register_2_i = 5'd0;
    ifc.Read_Register_1_i = 6'd0;  ifc.Read_Register_2_i = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_d1", 64'(ifa.Read_Data_1_o), 64'h0);
    check("rst_a_b2", 64'(ifa.Read_Busy_2_o), 64'h0);
    check("rst_a_cf", 64'(ifa.Busy_Conflict_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table on dut_a
    for (int i = 0; i < n_vecs; i++) begin
      @(negedge clk);
      ifa.Reg_Write_i       = vecs[i].we;
      ifa.Write_Register_i  = vecs[i].waddr;
      ifa.Write_Data_i      = vecs[i].wdata;
      ifa.Busy_Set_i        = vecs[i].set;
      ifa.Busy_Register_i   = vecs[i].baddr;
      ifa.Read_Register_1_i = vecs[i].ra1;
      ifa.Read_Register_2_i = vecs[i].ra2;
      #1;
      check($sformatf("v%0d_d1", i), 64'(ifa.Read_Data_1_o), 64'(vecs[i].e_d1));
      check($sformatf("v%0d_d2", i), 64'(ifa.Read_Data_2_o), 64'(vecs[i].e_d2));
      check($sformatf("v%0d_b1", i), 64'(ifa.Read_Busy_1_o), 64'(vecs[i].e_b1));
      check($sformatf("v%0d_b2", i), 64'(ifa.Read_Busy_2_o), 64'(vecs[i].e_b2));
      check($sformatf("v%0d_cf", i), 64'(ifa.Busy_Conflict_o), 64'(vecs[i].e_cf));
    end
    @(negedge clk);
    idle_all();

    // dut_b: no bypass, write visible only after the edge
    @(negedge clk);
    ifb.Reg_Write_i = 1; ifb.Write_Register_i = 5'd8; ifb.Write_Data_i = 32'hDEADBEEF;
    ifb.Read_Register_1_i = 5'd8; ifb.Read_Register_2_i = 5'd8;
    #1;
    check("nb_same_d1", 64'(ifb.Read_Data_1_o), 64'h0);
    check("nb_same_d2", 64'(ifb.Read_Data_2_o), 64'h0);
    @(posedge clk); #1;
    check("nb_next_d1", 64'(ifb.Read_Data_1_o), 64'hDEADBEEF);
    check("nb_next_d2", 64'(ifb.Read_Data_2_o), 64'hDEADBEEF);
    @(negedge clk);
    ifb.Reg_Write_i = 0; ifb.Busy_Set_i = 1; ifb.Busy_Register_i = 5'd10;
    ifb.Read_Register_1_i = 5'd10;
    #1;
    check("nb_set_b1", 64'(ifb.Read_Busy_1_o), 64'h0);
    @(negedge clk);
    ifb.Busy_Set_i = 0; ifb.Reg_Write_i = 1; ifb.Write_Register_i = 5'd10;
    ifb.Write_Data_i = 32'h5;
    #1;
    check("nb_wr_b1", 64'(ifb.Read_Busy_1_o), 64'h1);
    check("nb_wr_d1", 64'(ifb.Read_Data_1_o), 64'h0);
    @(posedge clk); #1;
    check("nb_after_b1", 64'(ifb.Read_Busy_1_o), 64'h0);
    check("nb_after_d1", 64'(ifb.Read_Data_1_o), 64'h5);
    @(negedge clk);
    idle_all();

    // dut_c: 64-bit / 6-bit address, top register
    @(negedge clk);
    ifc.Reg_Write_i = 1; ifc.Write_Register_i = 6'd63;
    ifc.Write_Data_i = 64'hFFFF_0000_FFFF_0000;
    ifc.Busy_Set_i = 1; ifc.Busy_Register_i = 6'd62;
    ifc.Read_Register_1_i = 6'd63; ifc.Read_Register_2_i = 6'd62;
    #1;
    check("w64_byp_d1", ifc.Read_Data_1_o, 64'hFFFF_0000_FFFF_0000);
    @(negedge clk);
    idle_all();
    #1;
    check("w64_rd_d1", ifc.Read_Data_1_o, 64'hFFFF_0000_FFFF_0000);
    check("w64_b2", 64'(ifc.Read_Busy_2_o), 64'h1);

    // Mid-operation reset with a write in flight
    @(negedge clk);
    ifc.Reg_Write_i = 1; ifc.Write_Register_i = 6'd63; ifc.Write_Data_i = 64'h1234;
    ifa.Read_Register_1_i = 5'd8;
    #2 rst = 1'b1;
    #1;
    check("arst_c_d1", ifc.Read_Data_1_o, 64'h0);
    check("arst_c_b2", 64'(ifc.Read_Busy_2_o), 64'h0);
    check("arst_a_d1", 64'(ifa.Read_Data_1_o), 64'h0);
    check("arst_a_cf", 64'(ifa.Busy_Conflict_o), 64'h0);
    @(posedge clk); #1;
    check("arst_edge_c_d1", ifc.Read_Data_1_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    #1;
    check("post_rst_c_d1", ifc.Read_Data_1_o, 64'h0);
    check("post_rst_c_b2", 64'(ifc.Read_Busy_2_o), 64'h0);
    check("post_rst_c_cf", 64'(ifc.Busy_Conflict_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the MIPS register file: a 2-read / 1-write register array with configurable width and depth, an optional hard-wired zero register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency producers such as loads and multiply/divide. It sits in the decode stage of the pipelined datapath. Read data and busy status feed the operand muxes and the hazard/stall unit; writes come from write-back.

## Interface
Parameters:
- N_bits, 32, data width of each register
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports (clock and reset are one clock and an asynchronous, active-high reset):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active high
- Reg_Write_i  in  1  write enable
- Write_Register_i  in  ADDR_W  write address
- Write_Data_i  in  N_bits  write data
- Read_Register_1_i  in  ADDR_W  read port 1 address
- Read_Register_2_i  in  ADDR_W  read port 2 address
- Read_Data_1_o  out  N_bits  read port 1 data
- Read_Data_2_o  out  N_bits  read port 2 data
- Busy_Set_i  in  1  mark a register as pending a write
- Busy_Register_i  in  ADDR_W  register to mark
- Read_Busy_1_o  out  1  operand 1 pending; the consumer must stall
- Read_Busy_2_o  out  1  operand 2 pending
- Busy_Conflict_o  out  1  sticky error flag

## Operation
- **Storage:** array of 2**ADDR_W × N_bits. Write occurs on the rising clk when Reg_Write_i=1. The write is suppressed for address 0 when ZERO_REG=1.
- **Read (combinational):** Read_Data_n_o = array[Read_Register_n_i], with these overrides:
  - ZERO_REG=1 and address 0: output is 0.
  - Otherwise, BYPASS=1, Reg_Write_i=1 and Write_Register_i equal to the read address: output is Write_Data_i.
- **Scoreboard:**
  - One busy bit per register.
  - At a rising edge, Busy_Set_i=1 sets busy[Busy_Register_i].
  - Reg_Write_i=1 clears busy[Write_Register_i].
  - Set and clear of the same address in the same edge: set wins, because a new producer supersedes the old one.
  - Busy_Set_i on address 0 with ZERO_REG=1 is ignored.
- **Read_Busy_n_o:** equals busy[Read_Register_n_i], with these exceptions:
  - It is 0 when BYPASS=1 and a write to that address is in progress this cycle, since the data is being forwarded.
  - It is 0 for address 0 when ZERO_REG=1.
  - Busy_Set_i in the current cycle does not affect Read_Busy until the next cycle.
- **Busy_Conflict_o:**
  - Set on any rising edge where Busy_Set_i=1 targets a register that is already busy and is not being cleared in that same edge.
  - Stays set until reset.
- **Reset:**
  - Array, busy bits and the conflict flag all go to 0 immediately.
  - Read_Data_n_o = 0, Read_Busy_n_o = 0, Busy_Conflict_o = 0 while reset is asserted and until the first write or set.
  - Reset asserted mid-operation discards pending busy state and any in-flight write edge.

## Timing
- Read-port latency is 0 cycles (combinational from address, array and bypass inputs).
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 cycle; new data is visible after the edge.
- Busy set visible 1 cycle after the set edge. Busy clear is visible in the write cycle (BYPASS=1) or after the write edge (BYPASS=0).
- No handshake on writes; every asserted cycle is accepted.
- Both read ports may address the same register, including the write target; both see identical data and busy.
- Address wrap does not apply: every ADDR_W value maps to a valid register.

## Structure
- Shared package regfile_pkg:
  - default N_bits and ADDR_W
  - REG_ZERO address constant (0)
  - typedef for the register word and the register address
- Sub-module regfile_scoreboard:
  - owns the busy vector and the conflict flag
  - inputs: set/clear and both read addresses
  - outputs: raw busy bits
- The top level holds the array, bypass muxing and ZERO_REG masking.

## Test plan
- Reset, then read addresses 5 and 31 → Read_Data = 0, Read_Busy = 0, Busy_Conflict_o = 0.
- Write 0xDEADBEEF to r8 while reading r8 on both ports (BYPASS=1) → both ports read 0xDEADBEEF in the same cycle. With BYPASS=0, both read 0 that cycle and 0xDEADBEEF the next.
- Write 0x12345678 to r0 with ZERO_REG=1, then read r0 → 0. Busy_Set_i on r0 → Read_Busy stays 0.
- Busy_Set_i r10, then read r10 → Read_Busy_1_o = 1. Write 0xA5 to r10 → busy reads 0 in the write cycle (BYPASS=1) and Read_Data = 0xA5. Set and write r10 in the same edge → r10 still busy.
- Busy_Set_i r3 twice with no intervening write → Busy_Conflict_o = 1 from the second edge, held until reset.
- Parameter sweep N_bits=64, ADDR_W=6: write 0xFFFF_0000_FFFF_0000 to r63 and read it back → exact value; assert reset mid-sequence → all outputs 0 asynchronously.
